vector_reduce_seq: RTL and testbench
====================================

Name: vector_reduce_seq

Overview:
- Sequential reducer: folds an ARR vector into one int scalar. This is the vector-to-scalar direction, complementing the scalar-to-vector elementwise blocks (scalar_subt, scalar_mult).
- Two operations: SUM for dot-product/bias accumulation, and MAX with argmax index for output-layer classification.
- Processes one element per cycle, with valid/ready handshakes on both input and output. Sits between the layer datapath and the result/controller logic.

Parameters:
- MAX_N, default `MAX_NEURONS: number of ARR elements, and the maximum reduction length.
- IDX_W, default $clog2(`MAX_NEURONS): width of length, index and internal counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request carries a valid vector, length and op.
- in_ready  output  1  block can accept a request; high only in IDLE.
- vector1  input  ARR (MAX_N x 32 signed)  operand vector, sampled on accept.
- length  input  IDX_W+1  number of active elements, starting at element 0.
- op  input  1  reduce_op_t: RED_SUM=0, RED_MAX=1.
- out_valid  output  1  result and index are valid.
- out_ready  input  1  consumer takes the result.
- result  output  int (32 signed)  reduction result.
- index  output  IDX_W  argmax position for RED_MAX; 0 for RED_SUM.

Behaviour:
- Reset (clk edge with rst=1), from any state including mid-reduction:
  - state goes to IDLE.
  - out_valid=0, result=0, index=0.
  - in_ready=1 on the cycle after reset.
  - Any in-flight request is discarded.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE, on accept (in_valid && in_ready):
  - Capture vector1, op and Lc = min(length, MAX_N) into registers.
  - acc <= vec[0], best_idx <= 0, cnt <= 1.
  - Next state is DONE if Lc<=1, otherwise RUN.
- Lc==0: result=0, index=0 regardless of op; same timing as Lc==1.
- RUN: each cycle fold vec[cnt] into acc, then cnt <= cnt+1. When cnt==Lc-1, fold and go to DONE.
- SUM: acc <= acc + vec[cnt], 32-bit two's complement, wraps silently with no saturation.
- MAX: signed compare. If vec[cnt] > acc (strictly greater), acc <= vec[cnt] and best_idx <= cnt. Ties keep the lowest index.
- Latency: accept at edge k gives out_valid high after edge k+max(Lc,1)-1. Throughput is one reduction per Lc+1 cycles minimum.
- DONE:
  - result = acc and index = best_idx (index=0 for SUM). Both held stable while out_valid=1.
  - When out_ready=1, go to IDLE. The next accept can happen no earlier than the following cycle; there is no bypass.
- out_ready while not in DONE is ignored. in_valid outside IDLE is ignored; the requester must hold it until accepted.
- Input vector changes after accept have no effect, because the operand is registered.
- No combinational path from in_valid/out_ready to in_ready/out_valid.

Decomposition:
- library_file.v (shared) already holds `MAX_NEURONS and ARR.
- Add to it: typedef enum logic {RED_SUM, RED_MAX} reduce_op_t.
- Sub-module reduce_alu (combinational):
  - inputs: acc, elem, op.
  - outputs: next_acc, take (take=1 when MAX replaces the best).
  - The FSM, counter, operand register and index tracking stay in vector_reduce_seq.

Test Plan:
1. SUM, length=4, vec={1,2,3,4,...}, out_ready=1:
   - out_valid after 3 cycles post-accept.
   - result=10, index=0.
   - in_ready high the cycle after handoff.
2. MAX, length=5, vec={-7,3,9,9,-1}: result=9, index=2 (tie keeps lowest index).
3. SUM wrap, length=2, vec={32'h7FFFFFFF,1}: result=32'h80000000 (-2147483648).
4. Edge lengths:
   - length=0, op=MAX: out_valid the cycle after accept, result=0, index=0.
   - length=MAX_N+3 with all-ones vector, SUM: clamped, result=MAX_N.
5. Backpressure: out_ready=0 for 6 cycles in DONE.
   - result/index stable throughout and in_ready=0.
   - in_valid pulses are ignored.
   - Release out_ready, then a new request is accepted.
6. rst=1 mid-RUN on a length-8 SUM:
   - next cycle out_valid=0, result=0, in_ready=1.
   - A following length=3 request {5,5,5} returns 15 with no residue from the old request.

Source files
------------

// File: rtl/vector_reduce_seq_pkg.sv
// Shared types for the sequential vector-to-scalar reducer.
package vector_reduce_seq_pkg;

    // Number of elements in an operand vector.
    localparam int MAX_NEURONS = 8;

    // One signed 32-bit vector element / scalar result.
    typedef logic signed [31:0] elem_t;

    // Reduction operation selector.
    typedef enum logic {
        RED_SUM = 1'b0,
        RED_MAX = 1'b1
    } reduce_op_t;

    // Controller states, also exported on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } reduce_state_t;

endpackage

// File: rtl/vector_reduce_seq_alu.sv
// Combinational fold step: combines the running accumulator with one element.
module vector_reduce_seq_alu
    import vector_reduce_seq_pkg::*;
(
    input  elem_t      acc,
    input  elem_t      elem,
    input  reduce_op_t op,
    output elem_t      next_acc,
    output logic       take
);

    // SUM wraps silently; MAX replaces only on a strictly greater element,
    // so ties keep the earlier (lower) index.
    always_comb begin
        take     = 1'b0;
        next_acc = acc;
        if (op == RED_SUM) begin
            next_acc = acc + elem;
        end else if (elem > acc) begin
            take     = 1'b1;
            next_acc = elem;
        end
    end

endmodule

// File: rtl/vector_reduce_seq.sv
// Sequential reducer: folds up to MAX_N registered elements into one scalar,
// one element per cycle, with SUM or MAX/argmax.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state (high in IDLE); out_valid depends
// only on state (high in DONE); neither has a combinational path from
// in_valid or out_ready. The requester holds in_valid until accepted, and
// result/index hold steady while out_valid is high.
module vector_reduce_seq
    import vector_reduce_seq_pkg::*;
#(
    parameter int MAX_N = MAX_NEURONS,
    parameter int IDX_W = $clog2(MAX_N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  elem_t         vector1 [MAX_N],
    input  logic [IDX_W:0] length,
    input  reduce_op_t    op,
    output logic          out_valid,
    input  logic          out_ready,
    output elem_t         result,
    output logic [IDX_W-1:0] index,
    output reduce_state_t dbg_state
);

    localparam logic [IDX_W:0]   LEN_MAX = (IDX_W + 1)'(MAX_N);
    localparam logic [IDX_W:0]   LEN_ONE = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

    reduce_state_t    state_q, state_d;
    elem_t            vec_q [MAX_N];
    elem_t            vec_d [MAX_N];
    reduce_op_t       op_q, op_d;
    logic [IDX_W:0]   len_q, len_d;
    elem_t            acc_q, acc_d;
    logic [IDX_W-1:0] best_q, best_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic [IDX_W:0]   len_clamped;
    elem_t            alu_next;
    logic             alu_take;

    // Requests longer than the vector are clamped to the full vector.
    assign len_clamped = (length > LEN_MAX) ? LEN_MAX : length;

    vector_reduce_seq_alu u_reduce_alu (
        .acc      (acc_q),
        .elem     (vec_q[cnt_q]),
        .op       (op_q),
        .next_acc (alu_next),
        .take     (alu_take)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        op_d    = op_q;
        len_d   = len_q;
        acc_d   = acc_q;
        best_d  = best_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    vec_d  = vector1;
                    op_d   = op;
                    len_d  = len_clamped;
                    // Zero-length requests report 0 for either operation.
                    acc_d  = (len_clamped == '0) ? '0 : vector1[0];
                    best_d = '0;
                    cnt_d  = CNT_ONE;
                    state_d = (len_clamped <= LEN_ONE) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = alu_next;
                if (alu_take) begin
                    best_d = cnt_q;
                end
                cnt_d = cnt_q + CNT_ONE;
                if ({1'b0, cnt_q} == (len_q - LEN_ONE)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and accumulator registers; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= RED_SUM;
            len_q   <= '0;
            acc_q   <= '0;
            best_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            best_q  <= best_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand vector register; contents only matter after an accept.
    always_ff @(posedge clk) begin
        vec_q <= vec_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = acc_q;
    assign index     = best_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vector_reduce_seq.sv
// Self-checking bench for vector_reduce_seq: directed scenarios plus
// randomized requests against a behavioural reference model.
module tb_vector_reduce_seq;
    import vector_reduce_seq_pkg::*;

    localparam int MAX_N = MAX_NEURONS;
    localparam int IDX_W = $clog2(MAX_N);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    elem_t            vector1 [MAX_N];
    logic [IDX_W:0]   length;
    reduce_op_t       op;
    logic             out_valid;
    logic             out_ready;
    elem_t            result;
    logic [IDX_W-1:0] index;
    reduce_state_t    dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    int          exp_idx_q[$];

    vector_reduce_seq #(.MAX_N(MAX_N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vector1   (vector1),
        .length    (length),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .index     (index),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // Reference: clamp length, then SUM is the wrapped total of the active
    // elements; MAX is the largest active value and the first position holding it.
    function automatic void model(input elem_t v [MAX_N], input int len, input logic is_max,
                                  output elem_t r, output int idx);
        int lc;
        lc  = (len > MAX_N) ? MAX_N : len;
        r   = 0;
        idx = 0;
        if (lc == 0) return;
        if (!is_max) begin
            for (int i = 0; i < lc; i++) r = r + v[i];
        end else begin
            r = v[0];
            for (int i = 1; i < lc; i++) if (v[i] > r) r = v[i];
            idx = -1;
            for (int i = 0; i < lc; i++) if (idx < 0 && v[i] == r) idx = i;
        end
    endfunction

    // Drive one request, check latency, result, index and the handoff.
    task automatic run_one(input elem_t v [MAX_N], input int len, input logic is_max, input string name);
        elem_t r;
        int    idx;
        int    lc;
        int    cycles;
        int    exp_lat;
        logic [31:0] e_res;
        int          e_idx;
        model(v, len, is_max, r, idx);
        exp_q.push_back(r);
        exp_idx_q.push_back(idx);
        lc      = (len > MAX_N) ? MAX_N : len;
        exp_lat = (lc < 1) ? 0 : lc - 1;
        @(negedge clk);
        cycles = 0;
        while (!in_ready && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        vector1  = v;
        length   = len[IDX_W:0];
        op       = is_max ? RED_MAX : RED_SUM;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble the inputs: the operand must already be registered.
        for (int i = 0; i < MAX_N; i++) vector1[i] = $urandom;
        op = is_max ? RED_SUM : RED_MAX;
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        e_res = exp_q.pop_front();
        e_idx = exp_idx_q.pop_front();
        n_cmp++;
        if (cycles !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, cycles, exp_lat);
        end
        n_cmp++;
        if (result !== e_res) begin
            n_err++;
            $display("FAIL %s result: got %0d, expected %0d", name, $signed(result), $signed(e_res));
        end
        n_cmp++;
        if (index !== e_idx[IDX_W-1:0]) begin
            n_err++;
            $display("FAIL %s index: got %0d, expected %0d", name, index, e_idx);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s handoff: in_ready=%b out_valid=%b, expected 1/0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        length = '0;
        op = RED_SUM;
        for (int i = 0; i < MAX_N; i++) vector1[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || index !== '0) begin
            n_err++;
            $display("FAIL reset: in_ready=%b out_valid=%b result=%0d index=%0d, expected 1/0/0/0",
                     in_ready, out_valid, result, index);
        end
    endtask

    task automatic test_sum_basic();
        elem_t v [MAX_N];
        for (int i = 0; i < MAX_N; i++) v[i] = i + 1;
        run_one(v, 4, 1'b0, "sum_len4");
    endtask

    task automatic test_max_tie();
        elem_t v [MAX_N];
        for (int i = 0; i < MAX_N; i++) v[i] = 100;
        v[0] = -7; v[1] = 3; v[2] = 9; v[3] = 9; v[4] = -1;
        run_one(v, 5, 1'b1, "max_tie");
    endtask

    task automatic test_sum_wrap();
        elem_t v [MAX_N];
        for (int i = 0; i < MAX_N; i++) v[i] = 0;
        v[0] = 32'h7FFFFFFF; v[1] = 1;
        run_one(v, 2, 1'b0, "sum_wrap");
        n_cmp++;
        if (result !== 32'h80000000) begin
            n_err++;
            $display("FAIL sum_wrap held: got %h, expected 80000000", result);
        end
    endtask

    task automatic test_edge_lengths();
        elem_t v [MAX_N];
        for (int i = 0; i < MAX_N; i++) v[i] = 50 + i;
        run_one(v, 0, 1'b1, "len0_max");
        run_one(v, 1, 1'b1, "len1_max");
        for (int i = 0; i < MAX_N; i++) v[i] = 1;
        run_one(v, MAX_N + 3, 1'b0, "len_clamp_sum");
        for (int i = 0; i < MAX_N; i++) v[i] = -i;
        v[MAX_N-1] = 1000;
        run_one(v, MAX_N, 1'b1, "max_last");
    endtask

    task automatic test_backpressure();
        elem_t v [MAX_N];
        elem_t w [MAX_N];
        int    cycles;
        for (int i = 0; i < MAX_N; i++) v[i] = 10 * i - 20;
        v[2] = 77;
        @(negedge clk);
        vector1 = v; length = 4; op = RED_MAX; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < MAX_N; i++) vector1[i] = $urandom;
            in_valid = k[0];
            length = 3;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'sd77 || index !== 3'(2)) begin
                n_err++;
                $display("FAIL backpressure hold %0d: out_valid=%b in_ready=%b result=%0d index=%0d, expected 1/0/77/2",
                         k, out_valid, in_ready, $signed(result), index);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < MAX_N; i++) w[i] = 3;
        run_one(w, 3, 1'b0, "after_backpressure");
    endtask

    task automatic test_reset_mid_run();
        elem_t v [MAX_N];
        for (int i = 0; i < MAX_N; i++) v[i] = 1000 + i;
        @(negedge clk);
        vector1 = v; length = 8; op = RED_SUM; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_run: out_valid=%b result=%0d in_ready=%b, expected 0/0/1",
                     out_valid, $signed(result), in_ready);
        end
        for (int i = 0; i < MAX_N; i++) v[i] = 5;
        run_one(v, 3, 1'b0, "after_reset_sum");
    endtask

    task automatic test_random();
        elem_t v [MAX_N];
        int    len;
        logic  is_max;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < MAX_N; i++) begin
                if (t[0]) v[i] = $urandom;
                else      v[i] = $signed($urandom_range(0, 10)) - 5;
            end
            len    = $urandom_range(0, MAX_N + 2);
            is_max = 1'($urandom_range(0, 1));
            run_one(v, len, is_max, "random");
        end
    endtask

    initial begin
        test_reset();
        test_sum_basic();
        test_max_tie();
        test_sum_wrap();
        test_edge_lengths();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
